// File: rtl/memoria_ram_dp.sv
// Dual-port data RAM: port A byte-write/read, port B read-only, 1 or 2 cycle read latency, post-reset clear sweep.
// Optional per-byte even parity with an err output when MEMORIA_RAM_PARITY_EN is defined.
module memoria_ram_dp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   douta,
  input  logic                enb,
  input  logic [ADDR_W-1:0]   addrb,
  output logic [DATA_W-1:0]   doutb,
`ifdef MEMORIA_RAM_PARITY_EN
  output logic [DATA_W/8-1:0] err,
`endif
  output logic                busy
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("memoria_ram_dp: DATA_W must be a multiple of 8");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("memoria_ram_dp: READ_LAT must be 1 or 2");
  end

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                w_busy;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_douta1;
  logic [DATA_W-1:0]   r_doutb1;

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      ST_IDLE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);
  assign busy   = w_busy;

  // Storage has no reset; the sweep zeroes it one word per cycle once rsta drops.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (w_busy) begin
        r_mem[r_clr_cnt] <= '0;
      end else begin
        for (int k = 0; k < NB; k++)
          if (wea[k]) r_mem[addra][8*k +: 8] <= dina[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta || w_busy) begin
      r_douta1 <= '0;
      r_doutb1 <= '0;
    end else begin
      r_douta1 <= r_mem[addra];
      if (enb) r_doutb1 <= r_mem[addrb];
    end
  end

`ifdef MEMORIA_RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] r_err1;
  logic [NB-1:0] w_err_now;

  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (w_busy) begin
        r_par[r_clr_cnt] <= '0;
      end else begin
        for (int k = 0; k < NB; k++)
          if (wea[k]) r_par[addra][k] <= ^dina[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_err_now = '0;
    for (int k = 0; k < NB; k++)
      w_err_now[k] = (^r_mem[addra][8*k +: 8]) ^ r_par[addra][k];
  end

  always_ff @(posedge clka) begin
    if (rsta || w_busy) r_err1 <= '0;
    else                r_err1 <= w_err_now;
  end
`endif

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_douta2;
    logic [DATA_W-1:0] r_doutb2;
    always_ff @(posedge clka) begin
      if (rsta || w_busy) begin
        r_douta2 <= '0;
        r_doutb2 <= '0;
      end else begin
        r_douta2 <= r_douta1;
        r_doutb2 <= r_doutb1;
      end
    end
    assign douta = r_douta2;
    assign doutb = r_doutb2;
`ifdef MEMORIA_RAM_PARITY_EN
    logic [NB-1:0] r_err2;
    always_ff @(posedge clka) begin
      if (rsta || w_busy) r_err2 <= '0;
      else                r_err2 <= r_err1;
    end
    assign err = r_err2;
`endif
  end else begin : g_lat1
    assign douta = r_douta1;
    assign doutb = r_doutb1;
`ifdef MEMORIA_RAM_PARITY_EN
    assign err = r_err1;
`endif
  end

endmodule

// File: tb/tb_memoria_ram_dp.sv
// Bench for memoria_ram_dp: one READ_LAT=1 and one READ_LAT=2 instance share stimulus and
// are checked every cycle against an array-based model, plus a vector table for byte enables/collision.
module tb_memoria_ram_dp;
  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic [3:0]  wea = '0;
  logic [5:0]  addra = '0;
  logic [31:0] dina = '0;
  logic        enb = 1'b0;
  logic [5:0]  addrb = '0;
  logic [31:0] douta1, doutb1, douta2, doutb2;
  logic        busy1, busy2;
`ifdef MEMORIA_RAM_PARITY_EN
  logic [3:0]  err1, err2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clka = ~clka;

  memoria_ram_dp #(.DATA_W(32), .ADDR_W(6), .READ_LAT(1)) dut1 (
    .clka(clka), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
    .enb(enb), .addrb(addrb), .doutb(doutb1),
`ifdef MEMORIA_RAM_PARITY_EN
    .err(err1),
`endif
    .busy(busy1));

  memoria_ram_dp #(.DATA_W(32), .ADDR_W(6), .READ_LAT(2)) dut2 (
    .clka(clka), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina), .douta(douta2),
    .enb(enb), .addrb(addrb), .doutb(doutb2),
`ifdef MEMORIA_RAM_PARITY_EN
    .err(err2),
`endif
    .busy(busy2));

  // Reference model: word array, busy-cycle count, and per-latency output values.
  logic [31:0] m_mem [64];
  logic        m_busy = 1'b1;
  int          m_sweep = 0;
  logic [31:0] m_a1 = '0, m_a2 = '0, m_b1 = '0, m_b2 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rsta) begin
      m_a1 = '0; m_a2 = '0; m_b1 = '0; m_b2 = '0;
      m_busy = 1'b1; m_sweep = 0;
    end else if (m_busy) begin
      m_a1 = '0; m_a2 = '0; m_b1 = '0; m_b2 = '0;
      m_sweep++;
      if (m_sweep == 64) begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_busy = 1'b0;
      end
    end else begin
      m_a2 = m_a1;
      m_b2 = m_b1;
      m_a1 = m_mem[addra];
      if (enb) m_b1 = m_mem[addrb];
      for (int k = 0; k < 4; k++)
        if (wea[k]) m_mem[addra][8*k +: 8] = dina[8*k +: 8];
    end
  endtask

  task automatic cycle();
    @(posedge clka);
    model_edge();
    #1;
    chk("busy_l1", {31'd0, busy1}, {31'd0, m_busy});
    chk("busy_l2", {31'd0, busy2}, {31'd0, m_busy});
    chk("douta_l1", douta1, m_a1);
    chk("douta_l2", douta2, m_a2);
    chk("doutb_l1", doutb1, m_b1);
    chk("doutb_l2", doutb2, m_b2);
`ifdef MEMORIA_RAM_PARITY_EN
    chk("err_l1", {28'd0, err1}, 32'd0);
    chk("err_l2", {28'd0, err2}, 32'd0);
`endif
  endtask

  task automatic idle_inputs();
    wea = '0; enb = 1'b0; dina = '0; addra = '0; addrb = '0;
  endtask

  // Cycles from reset release until busy falls; writes/reads attempted meanwhile must be ignored.
  task automatic sweep_len(input int stop_at, output int len);
    len = 0;
    rsta = 1'b0;
    while (busy1 && len < 200 && (stop_at < 0 || len < stop_at)) begin
      wea = 4'hF; addra = 6'd3; dina = 32'hDEAD_BEEF; enb = 1'b1; addrb = 6'd3;
      cycle();
      len++;
    end
    idle_inputs();
  endtask

  typedef struct {
    logic [3:0]  we;
    logic [5:0]  a;
    logic [31:0] din;
    logic        en;
    logic [5:0]  ab;
    logic [31:0] exp_a;
    logic        chk_b;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [7];
  int   len;

  initial begin
    vecs[0] = '{4'hF, 6'd5, 32'hAABBCCDD, 1'b0, 6'd0, 32'd5,          1'b0, 32'd0};
    vecs[1] = '{4'h5, 6'd5, 32'h11223344, 1'b0, 6'd0, 32'hAABBCCDD,   1'b0, 32'd0};
    vecs[2] = '{4'h0, 6'd5, 32'h0,        1'b0, 6'd0, 32'hAA22CC44,   1'b0, 32'd0};
    vecs[3] = '{4'hF, 6'd9, 32'h12345678, 1'b0, 6'd0, 32'd9,          1'b0, 32'd0};
    vecs[4] = '{4'hF, 6'd9, 32'hCAFEF00D, 1'b1, 6'd9, 32'h12345678,   1'b1, 32'h12345678};
    vecs[5] = '{4'h0, 6'd9, 32'h0,        1'b1, 6'd9, 32'hCAFEF00D,   1'b1, 32'hCAFEF00D};
    vecs[6] = '{4'h0, 6'd9, 32'h0,        1'b0, 6'd3, 32'hCAFEF00D,   1'b1, 32'hCAFEF00D};

    // Reset held for three cycles, then the sweep.
    rsta = 1'b1;
    repeat (3) cycle();
    sweep_len(-1, len);
    chk("sweep_len", len, 64);

    for (int i = 0; i < 64; i++) begin
      addra = 6'(i);
      cycle();
    end
    cycle();

    for (int i = 0; i < 64; i++) begin
      wea = 4'hF; addra = 6'(i); dina = 32'(i);
      cycle();
    end
    wea = '0;
    for (int i = 0; i < 64; i++) begin
      addra = 6'(i); enb = 1'b1; addrb = 6'(63 - i);
      cycle();
    end
    idle_inputs();
    cycle();

    foreach (vecs[i]) begin
      wea = vecs[i].we; addra = vecs[i].a; dina = vecs[i].din;
      enb = vecs[i].en; addrb = vecs[i].ab;
      cycle();
      chk($sformatf("vec%0d_douta", i), douta1, vecs[i].exp_a);
      if (vecs[i].chk_b) chk($sformatf("vec%0d_doutb", i), doutb1, vecs[i].exp_b);
    end
    idle_inputs();
    cycle();

    for (int i = 0; i < 400; i++) begin
      wea = 4'($urandom_range(0, 15)); addra = 6'($urandom_range(0, 63));
      dina = $urandom; enb = 1'($urandom_range(0, 1)); addrb = 6'($urandom_range(0, 63));
      if (i % 3 == 0) addrb = addra;
      cycle();
    end
    idle_inputs();

    // Reset 20 cycles into a sweep restarts it from the top.
    rsta = 1'b1;
    cycle();
    sweep_len(20, len);
    chk("sweep_partial", len, 20);
    rsta = 1'b1;
    cycle();
    sweep_len(-1, len);
    chk("sweep_restart_len", len, 64);
    addra = 6'd3;
    cycle();
    chk("addr3_after_busy", douta1, 32'd0);
    cycle();
    chk("addr3_after_busy_l2", douta2, 32'd0);

`ifdef MEMORIA_RAM_PARITY_EN
    wea = 4'hF; addra = 6'd7; dina = 32'h01020304;
    cycle();
    wea = '0;
    cycle();
    cycle();
    dut1.r_mem[7][0] = ~dut1.r_mem[7][0];
    dut2.r_mem[7][0] = ~dut2.r_mem[7][0];
    @(posedge clka); #1;
    chk("par_err_l1", {28'd0, err1}, 32'h1);
    @(posedge clka); #1;
    chk("par_err_l2", {28'd0, err2}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
